// File: rtl/vga_px_fetch.sv
// Pixel-stream prefetcher: fetches the grayscale frame as 32-bit words into a
// small word FIFO and emits one byte per visible pixel tick toward the VGA stage.
module vga_px_fetch #(
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned IMG_H       = 480,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  UNDERRUN_PX = 8'h00
) (
    input  logic        clk50MHz,
    input  logic        rst_n,
    input  logic        px_en,
    input  logic        frame_start,
    input  logic        px_active,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  memPx,
    output logic        underrun
);

    localparam int unsigned NWORDS = IMG_W * IMG_H / 4;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   word_idx;
    logic [CNT_W-1:0]   outstanding, discard_cnt;
    logic [CNT_W-1:0]   out_nxt, disc_nxt;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [1:0]         byte_sel;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [31:0]        fifo_head;
    logic [7:0]         head_byte;

    logic grant, push, pop, tick_vis, fifo_empty, credit_ok;

    // Words in the FIFO plus words in flight never exceed the FIFO depth,
    // so every return has a slot waiting for it.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < {1'b0, DEPTH_C};
    assign grant      = mem_req & mem_gnt;
    assign fifo_empty = (fifo_count == '0);
    assign mem_addr   = BASE_ADDR + (32'(word_idx) << 2);

    // Nothing streams before the first frame_start; frame_start overrides the tick.
    assign tick_vis = px_en & px_active & ~frame_start & (state_q != IDLE);
    assign push     = mem_rvalid & (discard_cnt == '0) & ~frame_start;
    assign pop      = tick_vis & ~fifo_empty & (byte_sel == 2'd3);

    assign fifo_head = fifo_mem[rd_ptr];
    assign head_byte = fifo_head[{byte_sel, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        if (state_q == FETCH) begin
            mem_req = credit_ok;
            if (credit_ok && mem_gnt && (word_idx == LAST_IDX))
                state_d = DONE;
        end else if (state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
        end
        if (frame_start) begin
            state_d = FETCH;
            mem_req = 1'b0;
        end
    end

    // Returns still in flight at frame_start belong to the old frame and are dropped.
    always_comb begin
        out_nxt  = outstanding;
        disc_nxt = discard_cnt;
        if (grant)
            out_nxt = out_nxt + CNT_ONE;
        if (mem_rvalid) begin
            if (discard_cnt == '0)
                out_nxt = out_nxt - CNT_ONE;
            else
                disc_nxt = disc_nxt - CNT_ONE;
        end
        if (frame_start) begin
            disc_nxt = disc_nxt + out_nxt;
            out_nxt  = '0;
        end
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_idx    <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            byte_sel    <= '0;
            memPx       <= 8'h00;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            outstanding <= out_nxt;
            discard_cnt <= disc_nxt;
            if (frame_start) begin
                word_idx   <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                byte_sel   <= '0;
                underrun   <= 1'b0;
            end else begin
                if (grant) word_idx <= word_idx + IDX_ONE;
                if (push)  wr_ptr   <= wr_ptr + PTR_ONE;
                if (pop)   rd_ptr   <= rd_ptr + PTR_ONE;
                if (push && !pop)
                    fifo_count <= fifo_count + CNT_ONE;
                else if (pop && !push)
                    fifo_count <= fifo_count - CNT_ONE;
                // An empty tick leaves byte_sel alone: the image stays shifted until the next frame.
                if (tick_vis) begin
                    if (fifo_empty)
                        underrun <= 1'b1;
                    else
                        byte_sel <= byte_sel + 2'd1;
                end
            end
            if (px_en) begin
                if (!tick_vis)
                    memPx <= 8'h00;
                else if (fifo_empty)
                    memPx <= UNDERRUN_PX;
                else
                    memPx <= head_byte;
            end
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk50MHz) begin
        if (rst_n && push && !pop)
            assert (fifo_count != DEPTH_C);
    end

endmodule

// File: tb/tb_vga_px_fetch.sv
// Directed bench for vga_px_fetch: small frame, behavioural memory with
// in-order returns, table-driven pixel stream plus stall/underrun/flush sequences.
module tb_vga_px_fetch;

    localparam int unsigned IMG_W      = 32;
    localparam int unsigned IMG_H      = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam logic [31:0] BASE       = 32'h0000_0100;
    localparam logic [7:0]  UPX        = 8'hEE;
    localparam int          NWORDS     = IMG_W * IMG_H / 4;

    logic        clk50MHz    = 1'b0;
    logic        rst_n       = 1'b0;
    logic        px_en       = 1'b0;
    logic        frame_start = 1'b0;
    logic        px_active   = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid  = 1'b0;
    logic [31:0] mem_rdata   = 32'h0;
    logic [7:0]  memPx;
    logic        underrun;

    bit gnt_en  = 1'b0;
    bit resp_en = 1'b1;
    bit poison  = 1'b0;

    typedef struct {
        int          ready_at;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        bit         act;
        logic [7:0] px;
        bit         und;
    } vec_t;

    rsp_t        rq[$];
    logic [31:0] gaddr[$];
    vec_t        vecs[$];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          wcnt;

    always #10 clk50MHz = ~clk50MHz;

    assign mem_gnt = mem_req & gnt_en;

    vga_px_fetch #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .UNDERRUN_PX(UPX)
    ) dut (
        .clk50MHz   (clk50MHz),
        .rst_n      (rst_n),
        .px_en      (px_en),
        .frame_start(frame_start),
        .px_active  (px_active),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .memPx      (memPx),
        .underrun   (underrun)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] k;
        k = (a - BASE) >> 2;
        return {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
    endfunction

    // Memory: grant is same-cycle; read data returns two cycles after the grant, in order.
    always @(posedge clk50MHz) begin
        if (mem_req && mem_gnt) begin
            gaddr.push_back(mem_addr);
            rq.push_back('{ready_at: cyc + 1, data: (poison ? 32'hA5A5_A5A5 : word_of(mem_addr))});
        end
        if (resp_en && rq.size() > 0 && rq[0].ready_at <= cyc) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= rq[0].data;
            void'(rq.pop_front());
        end else begin
            mem_rvalid <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk50MHz);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input bit act, input logic [7:0] exp_px, input string name);
        px_en     = 1'b1;
        px_active = act;
        step();
        check(name, 32'(memPx), 32'(exp_px));
        px_en = 1'b0;
        step();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        gaddr.delete();
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < IMG_W * IMG_H; p++) begin
            if (p % 16 == 5)
                vecs.push_back('{act: 1'b0, px: 8'h00, und: 1'b0});
            vecs.push_back('{act: 1'b1, px: 8'(p), und: 1'b0});
        end

        // Reset held with inputs toggling, then released without frame_start.
        gnt_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            px_en       = i[0];
            px_active   = 1'b1;
            frame_start = (i == 2);
            step();
            check("rst_req", 32'(mem_req), 0);
            check("rst_px", 32'(memPx), 0);
            check("rst_und", 32'(underrun), 0);
            check("rst_addr", mem_addr, BASE);
        end
        frame_start = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            px_en = i[0];
            step();
            check("idle_req", 32'(mem_req), 0);
            check("idle_px", 32'(memPx), 0);
            check("idle_und", 32'(underrun), 0);
        end
        px_en = 1'b0;

        // Full frame: prefill, then the table of active/blank ticks.
        pulse_fs();
        steps(30);
        check("prefill_grants", gaddr.size(), FIFO_DEPTH);
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].act, vecs[i].px, $sformatf("frame_px[%0d]", i));
            check($sformatf("frame_und[%0d]", i), 32'(underrun), 32'(vecs[i].und));
        end
        steps(4);
        check("done_grants", gaddr.size(), NWORDS);
        if (gaddr.size() == NWORDS)
            check("done_last_addr", gaddr[NWORDS-1], BASE + 32'(4 * (NWORDS - 1)));
        for (int i = 0; i < 4; i++) begin
            step();
            check("done_req", 32'(mem_req), 0);
        end
        tick(1'b0, 8'h00, "done_blank_px");

        // Responses held back: grants stop at FIFO_DEPTH outstanding.
        resp_en = 1'b0;
        pulse_fs();
        steps(30);
        check("credit_grants", gaddr.size(), FIFO_DEPTH);
        check("credit_req", 32'(mem_req), 0);
        check("credit_addr", mem_addr, BASE + 32'h40);
        gnt_en  = 1'b0;
        resp_en = 1'b1;
        steps(24);
        check("full_req", 32'(mem_req), 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(i), $sformatf("stall_px[%0d]", i));
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(mem_req), 1);
            check("stall_addr", mem_addr, BASE + 32'h40);
            step();
        end
        gnt_en = 1'b1;
        for (int i = 4; i < 12; i++) tick(1'b1, 8'(i), $sformatf("resume_px[%0d]", i));
        steps(3);
        check("resume_cnt_ok", 32'(gaddr.size() >= 18), 1);
        if (gaddr.size() >= 18) begin
            check("resume_addr0", gaddr[16], BASE + 32'h40);
            check("resume_addr1", gaddr[17], BASE + 32'h44);
        end

        // Memory stalled during active video: drain, underrun, recover shifted.
        pulse_fs();
        steps(40);
        gnt_en = 1'b0;
        for (int i = 0; i < 64; i++) tick(1'b1, 8'(i), $sformatf("drain_px[%0d]", i));
        check("drain_und", 32'(underrun), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, UPX, $sformatf("empty_px[%0d]", i));
            check("empty_und", 32'(underrun), 1);
        end
        gnt_en = 1'b1;
        steps(10);
        tick(1'b1, 8'h40, "shifted_px");
        check("sticky_und0", 32'(underrun), 1);
        tick(1'b0, 8'h00, "sticky_blank_px");
        check("sticky_und1", 32'(underrun), 1);
        pulse_fs();
        check("fs_clears_und", 32'(underrun), 0);
        steps(40);

        // frame_start with 5 reads in flight; one returns in the frame_start cycle.
        resp_en = 1'b0;
        poison  = 1'b1;
        pulse_fs();
        wcnt = 0;
        while (gaddr.size() < 5 && wcnt < 50) begin
            step();
            wcnt++;
        end
        gnt_en = 1'b0;
        steps(3);
        check("inflight_grants", gaddr.size(), 5);
        resp_en = 1'b1;
        step();
        poison = 1'b0;
        gnt_en = 1'b1;
        check("fs_rvalid_same_cycle", 32'(mem_rvalid), 1);
        pulse_fs();
        steps(40);
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), $sformatf("flush_px[%0d]", i));
        check("flush_und", 32'(underrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
